// File: rtl/proc_pkg.sv
// Types and constants shared by the data-memory controller and its RAM.
package proc_pkg;

    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/dm_ram_array.sv
// Single-port synchronous data RAM with registered read; contents survive reset.
module dm_ram_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 12,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
        o_dout <= r_mem[i_addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller feeding DR: latches a request, waits LATENCY cycles,
// then commits the write or returns read data with a one-cycle response.
module data_mem_ctrl #(
    parameter int DATA_W  = proc_pkg::DATA_W,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    import proc_pkg::*;

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    op_t                 r_op;
    logic                r_both;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_in_range;
    logic                w_err;
    logic                w_last;
    logic                w_ram_we;
    logic [AW-1:0]       w_ram_addr;
    logic [DATA_W-1:0]   w_ram_dout;

    assign w_in_range = ({1'b0, r_addr} < DEPTH_C);
    assign w_err      = !w_in_range || r_both;
    assign w_last     = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_ram_we   = w_last && (r_op == OP_WR) && !w_err;

    // In IDLE the RAM looks at the live address so that read data is already
    // registered by the end of the first ACCESS cycle (needed for LATENCY=1).
    assign w_ram_addr = (r_state == IDLE) ? i_addr[AW-1:0] : r_addr[AW-1:0];

    dm_ram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_din  (r_wdata),
        .o_dout (w_ram_dout)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_op          <= OP_RD;
            r_both        <= 1'b0;
            r_cnt         <= 4'd0;
            r_addr        <= '0;
            r_wdata       <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_rdata_valid <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_mem_read || i_mem_write) begin
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_op    <= i_mem_read ? OP_RD : OP_WR;
                        r_both  <= i_mem_read && i_mem_write;
                        r_cnt   <= 4'(LATENCY - 1);
                        o_busy  <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        o_done  <= 1'b1;
                        o_err   <= w_err;
                        r_state <= RESP;
                        if (r_op == OP_RD) begin
                            o_rdata_valid <= 1'b1;
                            o_rdata       <= w_in_range ? w_ram_dout : '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed, table-driven bench for data_mem_ctrl at the default LATENCY=2.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [11:0] wdata;
        logic [11:0] exp_rdata;
        logic        exp_v;
        logic        exp_e;
        string       name;
    } vec_t;

    vec_t vecs[11];

    data_mem_ctrl dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_mem_read    (mem_read),
        .i_mem_write   (mem_write),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_rdata       (rdata),
        .o_rdata_valid (rdata_valid),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one request, then check busy through ACCESS, the RESP outputs,
    // the latency to done, and the idle cycle that follows.
    task automatic do_req(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [11:0] d, input logic [11:0] exp_rd,
                          input logic exp_v, input logic exp_e, input string nm);
        int  k;
        bit  found;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = ~a;
        wdata     = ~d;
        k     = 1;
        found = 1'b0;
        while (k <= 10 && !found) begin
            if (done) begin
                found = 1'b1;
            end else begin
                chk({nm, "_busy_access"}, {31'd0, busy}, 32'd1);
                @(negedge clk);
                k++;
            end
        end
        chk({nm, "_latency"}, k, 3);
        chk({nm, "_busy_resp"}, {31'd0, busy}, 32'd1);
        chk({nm, "_valid"}, {31'd0, rdata_valid}, {31'd0, exp_v});
        chk({nm, "_err"}, {31'd0, err}, {31'd0, exp_e});
        chk({nm, "_rdata"}, {20'd0, rdata}, {20'd0, exp_rd});
        @(negedge clk);
        chk({nm, "_done_cleared"}, {31'd0, done}, 32'd0);
        chk({nm, "_busy_cleared"}, {31'd0, busy}, 32'd0);
        chk({nm, "_rdata_held"}, {20'd0, rdata}, {20'd0, exp_rd});
    endtask

    initial begin
        int k;
        int n_done;
        int second_k;

        vecs[0]  = '{1'b0, 1'b1, 12'h010, 12'hABC, 12'h000, 1'b0, 1'b0, "wr_010"};
        vecs[1]  = '{1'b1, 1'b0, 12'h010, 12'h000, 12'hABC, 1'b1, 1'b0, "rd_010"};
        vecs[2]  = '{1'b0, 1'b1, 12'h020, 12'h555, 12'hABC, 1'b0, 1'b0, "wr_020"};
        vecs[3]  = '{1'b1, 1'b1, 12'h020, 12'h111, 12'h555, 1'b1, 1'b1, "rdwr_020"};
        vecs[4]  = '{1'b1, 1'b0, 12'h020, 12'h000, 12'h555, 1'b1, 1'b0, "rd_020_kept"};
        vecs[5]  = '{1'b0, 1'b1, 12'h0FF, 12'h3C3, 12'h555, 1'b0, 1'b0, "wr_0ff"};
        vecs[6]  = '{1'b1, 1'b0, 12'h1FF, 12'h000, 12'h000, 1'b1, 1'b1, "rd_oor"};
        vecs[7]  = '{1'b0, 1'b1, 12'h1FF, 12'h123, 12'h000, 1'b0, 1'b1, "wr_oor"};
        vecs[8]  = '{1'b1, 1'b0, 12'h0FF, 12'h000, 12'h3C3, 1'b1, 1'b0, "rd_0ff_noalias"};
        vecs[9]  = '{1'b0, 1'b1, 12'h030, 12'h246, 12'h3C3, 1'b0, 1'b0, "wr_030"};
        vecs[10] = '{1'b1, 1'b0, 12'h010, 12'h000, 12'hABC, 1'b1, 1'b0, "rd_010_again"};

        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        repeat (2) @(negedge clk);
        chk("reset_rdata", {20'd0, rdata}, 32'd0);
        chk("reset_valid", {31'd0, rdata_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_v, vecs[i].exp_e, vecs[i].name);
        end

        // Reset during ACCESS aborts the pending write.
        @(negedge clk);
        mem_write = 1'b1;
        addr      = 12'h030;
        wdata     = 12'h777;
        @(negedge clk);
        mem_write = 1'b0;
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_rdata", {20'd0, rdata}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b1, 1'b0, 12'h030, 12'h000, 12'h246, 1'b1, 1'b0, "rd_030_after_rst");

        // A request pulsed while busy is ignored.
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 12'h010;
        @(negedge clk);
        addr     = 12'h0FF;
        n_done   = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) mem_read = 1'b0;
            if (done) n_done++;
            @(negedge clk);
        end
        chk("busy_ignore_done_count", n_done, 1);
        chk("busy_ignore_rdata", {20'd0, rdata}, 32'h0ABC);

        // A request held through RESP is re-accepted on the first IDLE edge.
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 12'h020;
        n_done   = 0;
        second_k = 0;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) mem_read = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 2) second_k = k;
            end
        end
        chk("held_done_count", n_done, 2);
        chk("held_second_done_cycle", second_k, 7);
        chk("held_rdata", {20'd0, rdata}, 32'h0555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller sitting directly upstream of the data register (DR).
- Accepts read/write requests from the control unit, owns the data-memory array, and models a configurable access latency.
- Read data goes out on rdata, with rdata_valid driving DR's writeEn_frDM load enable.
- Write data comes from DR's dataout.

Parameters:
- DATA_W, 12, data word width; matches the DR register width.
- ADDR_W, 12, address width as driven by the address register.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.
- LATENCY, 2, number of ACCESS cycles per request; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears FSM and all output registers.
- mem_read  input  1  read request from control unit (level, sampled in IDLE).
- mem_write  input  1  write request from control unit (level, sampled in IDLE).
- addr  input  ADDR_W  word address, latched on accept.
- wdata  input  DATA_W  write data from DR dataout, latched on accept.
- rdata  output  DATA_W  registered read data, held until the next completed read.
- rdata_valid  output  1  one-cycle pulse when rdata is newly valid; connects to DR writeEn_frDM.
- busy  output  1  high while a request is in flight (ACCESS or RESP).
- done  output  1  one-cycle pulse on completion of any request.
- err  output  1  one-cycle pulse in RESP if the request was illegal.

Behaviour:
- Reset values: state=IDLE, rdata=0, rdata_valid=0, busy=0, done=0, err=0, counter=0. Array contents are not cleared by reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On the edge where mem_read|mem_write=1, latch addr, wdata and op, load counter=LATENCY-1, go to ACCESS.
  - busy rises in the following cycle.
- ACCESS:
  - Lasts exactly LATENCY cycles.
  - Counter decrements each cycle; at counter=0 go to RESP.
  - On that transition edge:
    - A legal write commits latched wdata to array[latched addr].
    - A legal read loads array[latched addr] into rdata.
- RESP:
  - Single cycle: done=1, busy=1.
  - rdata_valid=1 for reads only.
  - Next state is IDLE.
- Latency: request seen at edge T gives rdata_valid/done high in cycle T+LATENCY+1 (3 cycles with the default). DR captures at the end of that cycle.
- Requests arriving while busy are ignored, not queued. The control unit holds or reissues them.
- mem_read and mem_write may only re-launch from IDLE, so a request held high through RESP is accepted again on the first IDLE edge.
- Simultaneous mem_read and mem_write at accept: read takes priority, the write is dropped, and err pulses in RESP.
- Out of range (latched addr >= DEPTH):
  - Read returns rdata=0 with rdata_valid=1 and err=1.
  - Write is dropped, array is unchanged, err=1.
- Changes on addr/wdata during ACCESS have no effect because the values are latched.
- Reset mid-ACCESS: the FSM returns to IDLE immediately, any pending write is aborted (array unchanged), and outputs clear asynchronously.
- Back-to-back requests: minimum spacing is LATENCY+2 cycles, i.e. accept, LATENCY ACCESS cycles, then RESP, with the next accept on the IDLE edge.
- rdata is never modified by writes or errors other than out-of-range reads.

Decomposition:
- Shared package proc_pkg holds:
  - DATA_W=12.
  - The state enum (IDLE, ACCESS, RESP).
  - Op encoding (OP_RD, OP_WR).
- One sub-module: dm_ram_array, a single-port synchronous RAM.
  - Parameters DEPTH and DATA_W.
  - Ports we, addr, din, dout; registered read.
  - The controller asserts the RAM enables on the ACCESS→RESP edge.

Test Plan:
- Reset, then write addr=0x010 wdata=0xABC with LATENCY=2 -> busy high for 3 cycles, done pulse at T+3, err=0, no rdata_valid.
- Read addr=0x010 after the write -> rdata=0xABC, rdata_valid and done pulse together at T+3, rdata holds 0xABC afterwards.
- Assert mem_read and mem_write together at addr=0x020 holding 0x555, wdata=0x111 -> rdata=0x555, err=1, array[0x020] still reads 0x555.
- Read addr=0x1FF (DEPTH=256) -> rdata=0x000, rdata_valid=1, err=1; write to 0x1FF -> err=1, no array change.
- Write 0x777 to 0x030, assert reset mid-ACCESS, then read 0x030 -> prior contents returned, not 0x777; all outputs 0 during reset.
- Pulse mem_read during busy with a different addr -> ignored, exactly one done pulse, rdata from the originally latched address.
